sleepy_spi_host: RTL and testbench
==================================

SLEEPY_SPI_HOST -- requirements
Module: sleepy_spi_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter FRAME_BITS, default 16, bits per frame (fixed at 16; other values out of scope).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, host request present.
REQ-006 SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 SHALL have port req_write, input, 1, 1 = write frame, 0 = read frame.
REQ-008 SHALL have port req_addr, input, 7, target register address.
REQ-009 SHALL have port req_data, input, 8, write data (ignored on reads but still shifted out).
REQ-010 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port rsp_data, output, 8, data captured from MISO during the data byte.
REQ-012 SHALL have port spi_sclk, output, 1, serial clock driven onto the target's ui_in pin.
REQ-013 SHALL have port spi_cs_n, output, 1, active-low chip select.
REQ-014 SHALL have port spi_mosi, output, 1, serial data out.
REQ-015 SHALL have port spi_miso, input, 1, serial data in, sampled from the target's uo_out pin.

Function
REQ-016 SHALL form frame = {req_write, req_addr, req_data} and shift it MSB first.
REQ-017 SHALL implement SPI mode 0: sclk idles low; mosi changes only while sclk is low; miso is sampled on the clk cycle where sclk goes 0->1.
REQ-018 SHALL implement FSM states IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE.
REQ-019 SHALL assert req_ready only in IDLE; a transfer is accepted on req_valid && req_ready.
REQ-020 SHALL, on acceptance at cycle 0: drive cs_n low from cycle 1, stay in SETUP for CLK_DIV cycles, then run 16 bits of SHIFT_LO (CLK_DIV cycles) + SHIFT_HI (CLK_DIV cycles), then HOLD for CLK_DIV cycles with sclk low.
REQ-021 SHALL, in DONE (cycle 1+34*CLK_DIV), drive cs_n high, pulse rsp_valid for exactly one cycle, and return to IDLE the next cycle.
REQ-022 SHALL present mosi for bit n throughout SHIFT_LO and SHIFT_HI of that bit; mosi = 0 outside SHIFT states.
REQ-023 SHALL hold rsp_data stable from the rsp_valid pulse until the next rsp_valid.
REQ-024 SHALL ignore req_* while not in IDLE; no request is queued.
REQ-025 SHALL treat req_valid held high during DONE as a new request only once IDLE is re-entered (minimum one idle cycle of cs_n high between frames).
REQ-026 SHALL ignore rsp backpressure: rsp_valid is not acknowledged.

Reset
REQ-027 SHALL, while rst is high, force state IDLE, spi_cs_n = 1, spi_sclk = 0, spi_mosi = 0, rsp_valid = 0, rsp_data = 0, req_ready = 0, divider and bit counters = 0.
REQ-028 SHALL, on rst mid-frame, abort on the next edge without rsp_valid; cs_n high the cycle after rst is sampled.
REQ-029 SHALL raise req_ready the first cycle after rst deasserts.

Configuration
REQ-030 SHALL support macro SLEEPY_HOST_READBACK_EN: defined -> miso captured into rsp_data during the last 8 bits; undefined -> rsp_data constant 0, spi_miso port present but unused.

Structure
REQ-031 SHALL place the FSM state enum, FRAME_BITS, and frame field bit positions (RW=15, ADDR=14:8, DATA=7:0) in package sleepy_host_pkg.
REQ-032 SHALL use one sub-module, sleepy_clk_div, producing a one-cycle tick every CLK_DIV cycles, restartable by the FSM.

Verification
REQ-033 SHALL cover: write addr 0x12 data 0xA5, CLK_DIV=4 -> MOSI bits 1_0010010_10100101, rsp_valid at cycle 137 after accept.
REQ-034 SHALL cover: read addr 0x05 with a model target returning 0x3C (READBACK_EN defined) -> rsp_data = 0x3C; macro undefined -> rsp_data = 0x00.
REQ-035 SHALL cover: CLK_DIV=1 write 0x7F/0xFF -> 16 sclk pulses of period 2, rsp_valid at cycle 35.
REQ-036 SHALL cover: rst asserted at bit 7 -> cs_n high next cycle, no rsp_valid, req_ready high first cycle after rst drops.
REQ-037 SHALL cover: req_valid held high for two back-to-back requests -> second accepted only after one cycle of req_ready high in IDLE, with cs_n high in that cycle.

Source files
------------

// File: rtl/sleepy_host_pkg.sv
// sleepy_host_pkg: FSM states, frame geometry and frame packing for sleepy_spi_host
package sleepy_host_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, DONE} state_t;
  localparam int FRAME_BITS = 16;
  localparam int RW_POS = 15;
  localparam int ADDR_HI = 14;
  localparam int ADDR_LO = 8;
  localparam int DATA_HI = 7;
  localparam int DATA_LO = 0;
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    f[RW_POS] = rw;
    f[ADDR_HI:ADDR_LO] = addr;
    f[DATA_HI:DATA_LO] = data;
    return f;
  endfunction
endpackage

// File: rtl/sleepy_clk_div.sv
// sleepy_clk_div: restartable divider giving a one-cycle tick every CLK_DIV clocks
module sleepy_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);
  logic [7:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk)
    cnt <= (rst || restart || tick) ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/sleepy_spi_host.sv
// sleepy_spi_host: SPI mode-0 register-frame host; SLEEPY_HOST_READBACK_EN enables MISO capture into rsp_data
module sleepy_spi_host #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  import sleepy_host_pkg::*;
  state_t                state;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  tick;
`ifdef SLEEPY_HOST_READBACK_EN
  logic [7:0]            rx;
`else
  logic                  unused_miso;
  assign unused_miso = spi_miso;
`endif
  sleepy_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .restart(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
      req_ready <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= '0;
`ifdef SLEEPY_HOST_READBACK_EN
      rx        <= 8'd0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE:
          if (req_valid && req_ready) begin
            state     <= SETUP;
            spi_cs_n  <= 1'b0;
            req_ready <= 1'b0;
            bit_cnt   <= 4'd0;
            shreg     <= make_frame(req_write, req_addr, req_data);
          end else
            req_ready <= 1'b1;
        SETUP:
          if (tick) begin
            state    <= SHIFT_LO;
            spi_mosi <= shreg[FRAME_BITS-1];
            shreg    <= shreg << 1;
          end
        SHIFT_LO:
          if (tick) begin
            state    <= SHIFT_HI;
            spi_sclk <= 1'b1;
`ifdef SLEEPY_HOST_READBACK_EN
            if (bit_cnt[3])
              rx <= {rx[6:0], spi_miso};
`endif
          end
        SHIFT_HI:
          if (tick) begin
            spi_sclk <= 1'b0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state    <= HOLD;
              spi_mosi <= 1'b0;
            end else begin
              state    <= SHIFT_LO;
              bit_cnt  <= bit_cnt + 4'd1;
              spi_mosi <= shreg[FRAME_BITS-1];
              shreg    <= shreg << 1;
            end
          end
        HOLD:
          if (tick) begin
            state     <= DONE;
            spi_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
`ifdef SLEEPY_HOST_READBACK_EN
            rsp_data  <= rx;
`endif
          end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sleepy_spi_host.sv
// tb_sleepy_spi_host: randomized and directed frames against a spec-level host/target model
module tb_sleepy_spi_host;
  localparam int D0 = 4;
  localparam int D1 = 1;
`ifdef SLEEPY_HOST_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       req_valid = 1'b0, req_write = 1'b0, req_ready, rsp_valid, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [6:0] req_addr = 7'd0;
  logic [7:0] req_data = 8'd0, rsp_data;
  logic       req_valid_1 = 1'b0, req_write_1 = 1'b0, req_ready_1, rsp_valid_1, spi_sclk_1, spi_cs_n_1, spi_mosi_1;
  logic       spi_miso_1 = 1'b0;
  logic [6:0] req_addr_1 = 7'd0;
  logic [7:0] req_data_1 = 8'd0, rsp_data_1;
  int vectors = 0, miscompares = 0;
  sleepy_spi_host #(.CLK_DIV(D0)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );
  sleepy_spi_host #(.CLK_DIV(D1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid_1), .req_ready(req_ready_1), .req_write(req_write_1),
    .req_addr(req_addr_1), .req_data(req_data_1), .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1),
    .spi_sclk(spi_sclk_1), .spi_cs_n(spi_cs_n_1), .spi_mosi(spi_mosi_1), .spi_miso(spi_miso_1)
  );
  // Bus monitor and target model, sampled mid-cycle on the falling clk edge
  int          cyc_n = 0, nrise = 0, last_rise = 0, bad_period = 0, n_rsp = 0, bad_idle = 0;
  logic [15:0] mosi_bits = 16'd0;
  logic [7:0]  tgt_byte = 8'd0;
  logic        sclk_prev = 1'b0;
  int          nrise_1 = 0, last_rise_1 = 0, bad_period_1 = 0;
  logic [15:0] mosi_bits_1 = 16'd0;
  logic        sclk_prev_1 = 1'b0;
  always @(negedge clk) begin
    cyc_n++;
    if (rsp_valid) n_rsp++;
    if (spi_cs_n && (spi_mosi || spi_sclk)) bad_idle++;
    if (spi_cs_n) begin
      nrise = 0;
      mosi_bits = 16'd0;
      bad_period = 0;
    end else if (spi_sclk && !sclk_prev) begin
      if (nrise > 0 && cyc_n - last_rise != 2 * D0) bad_period++;
      last_rise = cyc_n;
      mosi_bits = {mosi_bits[14:0], spi_mosi};
      nrise++;
    end
    sclk_prev = spi_sclk;
    if (spi_cs_n_1) begin
      nrise_1 = 0;
      mosi_bits_1 = 16'd0;
      bad_period_1 = 0;
    end else if (spi_sclk_1 && !sclk_prev_1) begin
      if (nrise_1 > 0 && cyc_n - last_rise_1 != 2 * D1) bad_period_1++;
      last_rise_1 = cyc_n;
      mosi_bits_1 = {mosi_bits_1[14:0], spi_mosi_1};
      nrise_1++;
    end
    sclk_prev_1 = spi_sclk_1;
  end
  assign spi_miso = (nrise >= 8 && nrise < 16) ? tgt_byte[3'(15 - nrise)] : 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frame0(input logic w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] tbyte, input logic hold);
    int cyc;
    logic [7:0] exp_rsp;
    tgt_byte = tbyte;
    req_write = w;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    check("cs_low_cycle1", spi_cs_n, 0);
    check("ready_low_busy", req_ready, 0);
    cyc = 1;
    while (!rsp_valid && cyc < 40 * D0) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rsp_latency", cyc, D0 + 2 * D0 * 16 + D0 + 1);
    check("rsp_valid", rsp_valid, 1);
    check("cs_high_done", spi_cs_n, 1);
    check("ready_low_done", req_ready, 0);
    check("mosi_frame", mosi_bits, {w, a, d});
    check("sclk_pulses", nrise, 16);
    check("sclk_period", bad_period, 0);
    exp_rsp = RB ? tbyte : 8'd0;
    check("rsp_data", rsp_data, exp_rsp);
    @(posedge clk); #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_idle", req_ready, 1);
    check("cs_idle", spi_cs_n, 1);
    check("rsp_data_hold", rsp_data, exp_rsp);
  endtask

  initial begin
    int cyc, rsp_before;
    logic [7:0] held;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_ready_1", req_ready_1, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", req_ready, 1);
    frame0(1'b1, 7'h12, 8'hA5, 8'h5A, 1'b0);
    frame0(1'b0, 7'h05, 8'h00, 8'h3C, 1'b0);
    for (int i = 0; i < 6; i++)
      frame0(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    frame0(1'b1, 7'h33, 8'h81, 8'hC3, 1'b1);
    frame0(1'b0, 7'h44, 8'h7E, 8'h96, 1'b0);
    check("mosi_idle_zero", bad_idle, 0);
    held = rsp_data;
    req_write = 1'b1;
    req_addr = 7'h2A;
    req_data = 8'hF0;
    tgt_byte = 8'hFF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_before = n_rsp;
    cyc = 0;
    while (nrise < 7 && cyc < 20 * D0) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_bit7", nrise, 7);
    check("rsp_data_stable_midframe", rsp_data, held);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_mosi", spi_mosi, 0);
    check("abort_ready", req_ready, 0);
    check("abort_rsp_data", rsp_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", req_ready, 1);
    repeat (40 * D0) @(posedge clk);
    #1;
    check("abort_no_rsp", n_rsp, rsp_before);
    check("abort_cs_stays_high", spi_cs_n, 1);
    req_write_1 = 1'b1;
    req_addr_1 = 7'h7F;
    req_data_1 = 8'hFF;
    req_valid_1 = 1'b1;
    check("ready1_idle", req_ready_1, 1);
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    check("cs1_low", spi_cs_n_1, 0);
    cyc = 1;
    while (!rsp_valid_1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rsp1_latency", cyc, D1 + 2 * D1 * 16 + D1 + 1);
    check("rsp1_data", rsp_data_1, 0);
    check("mosi1_frame", mosi_bits_1, 16'hFFFF);
    check("sclk1_pulses", nrise_1, 16);
    check("sclk1_period", bad_period_1, 0);
    @(posedge clk); #1;
    check("rsp1_one_cycle", rsp_valid_1, 0);
    check("ready1_back", req_ready_1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
